// File: rtl/rom_program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_program_loader_pkg
//  Purpose  : Shared state encoding and ROM interface widths for the loader.
//  Revision : 1.0 - initial release
// ============================================================================
package rom_program_loader_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

endpackage : rom_program_loader_pkg
`default_nettype wire

// File: rtl/rom_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_program_loader
//  Purpose  : Copies the program ROM into instruction memory on a start pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_program_loader
    import rom_program_loader_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = ROM_DATA_W,
    parameter int MEM_AW    = 8,
    parameter int MEM_BASE  = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rom_noi,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_set_addr,
    output logic              rom_en_data,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   c_max_words = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [MEM_AW-1:0] c_mem_base  = MEM_AW'(MEM_BASE);
    localparam logic [ADDR_W:0]   c_one       = (ADDR_W + 1)'(1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [ADDR_W:0]   w_noi_ext;
    logic              w_ovf;
    logic [ADDR_W:0]   w_n_clip;

    assign w_noi_ext = {1'b0, rom_noi};
    assign w_ovf     = (w_noi_ext > c_max_words);
    assign w_n_clip  = w_ovf ? c_max_words : w_noi_ext;

    assign count    = count_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            data_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            data_q     <= data_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decode from the state only, so IDLE drives every strobe and bus to zero.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        data_d       = data_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        rom_addr     = '0;
        rom_set_addr = 1'b0;
        rom_en_data  = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d        = w_n_clip;
                    overflow_d = w_ovf;
                    idx_d      = '0;
                    count_d    = '0;
                    state_d    = (w_n_clip != '0) ? ST_SET : ST_DONE;
                end
            end
            ST_SET: begin
                busy         = 1'b1;
                rom_addr     = idx_q[ADDR_W-1:0];
                rom_set_addr = 1'b1;
                state_d      = ST_READ;
            end
            ST_READ: begin
                busy        = 1'b1;
                rom_en_data = 1'b1;
                data_d      = rom_data;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = c_mem_base + MEM_AW'(idx_q);
                mem_wdata = data_q;
                if (mem_ready) begin
                    count_d = count_q + c_one;
                    idx_d   = idx_q + c_one;
                    state_d = ((idx_q + c_one) == n_q) ? ST_DONE : ST_SET;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule : rom_program_loader
`default_nettype wire
